ctl_score: RTL and testbench
============================

CTL_SCORE -- requirements
Module: ctl_score

Interface
REQ-001 Parameter AMMO_INIT, default 8'h20: initial ammo as two BCD digits (tens, ones), value 20.
REQ-002 Parameter RESPAWN_FRAMES, default 60: frames to wait after a hit before a new duck is requested; legal range 1..255.
REQ-003 Parameter BLINK_FRAMES, default 32: frames per half-period of the game-over blink; legal range 1..255.
REQ-004 clk  input  1  system clock, 65 MHz; the module uses this single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 new_frame  input  1  one-cycle pulse at the start of each video frame.
REQ-007 shot_fired  input  1  one-cycle pulse; the trigger was pulled.
REQ-008 hit  input  1  one-cycle pulse; the shot hit the duck.
REQ-009 miss  input  1  one-cycle pulse; the shot missed.
REQ-010 hex0  output  4  ammo ones digit, BCD.
REQ-011 hex1  output  4  ammo tens digit, BCD.
REQ-012 hex2  output  4  score ones digit, BCD.
REQ-013 hex3  output  4  score tens digit, BCD.
REQ-014 dp_in  output  4  decimal-point pattern for the 7-segment multiplexer.
REQ-015 duck_respawn  output  1  one-cycle pulse requesting a new duck flight.
REQ-016 game_over  output  1  level signal, high while the module is in state OVER.

Function
REQ-017 The state machine SHALL have three states: PLAY, RESPAWN and OVER.
REQ-018 In PLAY, each shot_fired SHALL decrement ammo by 1 as a BCD down-count, with a ones-digit borrow (x0 -> (x-1)9).
REQ-019 A shot_fired that arrives when ammo is 00 SHALL be ignored; ammo SHALL never underflow.
REQ-020 In PLAY, a hit SHALL increment score by 1 as a BCD up-count with carry (09 -> 10).
- Score saturates at 99.
- A hit also moves the state to RESPAWN and clears the frame counter.
REQ-021 shot_fired and hit in the same cycle SHALL both take effect in that cycle (ammo down, score up, state to RESPAWN).
REQ-022 In PLAY, a miss with ammo 00 (including a miss in the same cycle as the shot that decrements ammo to 00) SHALL move the state to OVER.
REQ-023 In PLAY, a miss with ammo other than 00 SHALL have no effect.
REQ-024 In RESPAWN, the frame counter SHALL count new_frame pulses.
- On the RESPAWN_FRAMES-th pulse, duck_respawn is asserted for exactly one cycle.
- In that same cycle the state leaves RESPAWN: to PLAY if ammo is not 00, to OVER if ammo is 00.
REQ-025 In RESPAWN, hit and miss SHALL be ignored, and shot_fired SHALL still decrement ammo under the rules of REQ-018 and REQ-019.
REQ-026 In OVER, hit and miss SHALL be ignored, and ammo and score SHALL hold their values.
- A shot_fired in OVER restarts the game: ammo = AMMO_INIT, score = 00, one-cycle duck_respawn pulse, state to PLAY, and the shot does not decrement ammo.
REQ-027 dp_in SHALL equal 4'b1011 in PLAY and in RESPAWN.
REQ-028 In OVER, dp_in SHALL start at 4'b0000 and toggle between 4'b0000 and 4'b1111 every BLINK_FRAMES new_frame pulses.
REQ-029 All outputs SHALL be registered, so each output changes one clk cycle after the input event that causes it.
REQ-030 The BCD digits SHALL never hold a value above 9.

Reset
REQ-031 On rst, the module SHALL enter PLAY with the following values:
- ammo = AMMO_INIT and score = 00;
- frame and blink counters = 0;
- duck_respawn = 0, game_over = 0, dp_in = 4'b1011.
REQ-032 rst SHALL take priority over every other input in the same cycle and SHALL abort RESPAWN or OVER immediately, without generating a duck_respawn pulse.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Reset, then 20 shot_fired pulses with no hit -> hex1/hex0 pass through 1/9 and 1/0 and end at 0/0; a further shot leaves them at 0/0.
- One shot_fired and one hit in the same cycle from reset -> ammo 19, score 01, RESPAWN; duck_respawn pulses exactly 1 cycle after the 60th new_frame and the state returns to PLAY.
- Score preloaded to 99 by a 99-hit sequence, then a further hit -> score stays 99.
- Ammo 01, then shot_fired followed by miss -> game_over = 1, dp_in = 0000; after 32 frames dp_in = 1111, after 64 frames dp_in = 0000.
- In OVER, a shot_fired -> ammo 20, score 00, one duck_respawn pulse, game_over = 0, dp_in = 1011.
- rst asserted in mid-RESPAWN at frame 30 -> PLAY, ammo 20, score 00, and no duck_respawn pulse.

Source files
------------

// File: rtl/ctl_score.sv
// Scoreboard/ammo controller for a duck-shooting game: BCD ammo and score digits,
// duck respawn timing after a hit, and the game-over blink pattern.
//
// state   | meaning
// --------+-------------------------------------------------------------
// PLAY    | normal play; shots spend ammo, hits score, miss at 00 ends
// RESPAWN | duck was hit; counting frames before requesting a new duck
// OVER    | out of ammo after a miss; decimal points blink, shot restarts
module ctl_score #(
  parameter logic [7:0] AMMO_INIT      = 8'h20,
  parameter int         RESPAWN_FRAMES = 60,
  parameter int         BLINK_FRAMES   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       shot_fired,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_in,
  output logic       duck_respawn,
  output logic       game_over
);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    RESPAWN = 2'd1,
    OVER    = 2'd2
  } state_t;

  localparam logic [7:0] RESP_LAST  = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0] DP_PLAY    = 4'b1011;

  state_t     state, state_nxt;
  logic [3:0] ammo_t, ammo_o, ammo_t_nxt, ammo_o_nxt;
  logic [3:0] score_t, score_o, score_t_nxt, score_o_nxt;
  logic [7:0] frame_cnt, frame_nxt;
  logic [7:0] blink_cnt, blink_nxt;
  logic [3:0] dp_r, dp_nxt;
  logic       dr_r, dr_nxt;
  logic       go_r, go_nxt;

  logic       ammo_zero;
  logic [3:0] post_t, post_o;
  logic       post_zero;
  logic [3:0] inc_t, inc_o;

  // Ammo after this cycle's shot (if any) and the saturating score increment.
  always_comb begin
    ammo_zero = (ammo_t == 4'd0) && (ammo_o == 4'd0);
    post_t    = ammo_t;
    post_o    = ammo_o;
    if (shot_fired && !ammo_zero) begin
      if (ammo_o == 4'd0) begin
        post_o = 4'd9;
        post_t = ammo_t - 4'd1;
      end else begin
        post_o = ammo_o - 4'd1;
      end
    end
    post_zero = (post_t == 4'd0) && (post_o == 4'd0);

    inc_t = score_t;
    inc_o = score_o;
    if (!(score_t == 4'd9 && score_o == 4'd9)) begin
      if (score_o == 4'd9) begin
        inc_o = 4'd0;
        inc_t = score_t + 4'd1;
      end else begin
        inc_o = score_o + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ammo_t_nxt  = ammo_t;
    ammo_o_nxt  = ammo_o;
    score_t_nxt = score_t;
    score_o_nxt = score_o;
    frame_nxt   = frame_cnt;
    blink_nxt   = blink_cnt;
    dp_nxt      = dp_r;
    dr_nxt      = 1'b0;

    case (state)
      PLAY: begin
        ammo_t_nxt = post_t;
        ammo_o_nxt = post_o;
        dp_nxt     = DP_PLAY;
        if (hit) begin
          score_t_nxt = inc_t;
          score_o_nxt = inc_o;
          frame_nxt   = 8'd0;
          state_nxt   = RESPAWN;
        end else if (miss && post_zero) begin
          blink_nxt = 8'd0;
          dp_nxt    = 4'b0000;
          state_nxt = OVER;
        end
      end

      RESPAWN: begin
        ammo_t_nxt = post_t;
        ammo_o_nxt = post_o;
        dp_nxt     = DP_PLAY;
        if (new_frame) begin
          if (frame_cnt == RESP_LAST) begin
            frame_nxt = 8'd0;
            dr_nxt    = 1'b1;
            if (post_zero) begin
              blink_nxt = 8'd0;
              dp_nxt    = 4'b0000;
              state_nxt = OVER;
            end else begin
              state_nxt = PLAY;
            end
          end else begin
            frame_nxt = frame_cnt + 8'd1;
          end
        end
      end

      OVER: begin
        if (shot_fired) begin
          // restart: the triggering shot is not charged against the fresh ammo
          ammo_t_nxt  = AMMO_INIT[7:4];
          ammo_o_nxt  = AMMO_INIT[3:0];
          score_t_nxt = 4'd0;
          score_o_nxt = 4'd0;
          frame_nxt   = 8'd0;
          blink_nxt   = 8'd0;
          dp_nxt      = DP_PLAY;
          dr_nxt      = 1'b1;
          state_nxt   = PLAY;
        end else if (new_frame) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_nxt = 8'd0;
            dp_nxt    = ~dp_r;
          end else begin
            blink_nxt = blink_cnt + 8'd1;
          end
        end
      end

      default: begin
        state_nxt = PLAY;
        dp_nxt    = DP_PLAY;
      end
    endcase

    go_nxt = (state_nxt == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLAY;
      ammo_t    <= AMMO_INIT[7:4];
      ammo_o    <= AMMO_INIT[3:0];
      score_t   <= 4'd0;
      score_o   <= 4'd0;
      frame_cnt <= 8'd0;
      blink_cnt <= 8'd0;
      dp_r      <= DP_PLAY;
      dr_r      <= 1'b0;
      go_r      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ammo_t    <= ammo_t_nxt;
      ammo_o    <= ammo_o_nxt;
      score_t   <= score_t_nxt;
      score_o   <= score_o_nxt;
      frame_cnt <= frame_nxt;
      blink_cnt <= blink_nxt;
      dp_r      <= dp_nxt;
      dr_r      <= dr_nxt;
      go_r      <= go_nxt;
    end
  end

  assign hex0         = ammo_o;
  assign hex1         = ammo_t;
  assign hex2         = score_o;
  assign hex3         = score_t;
  assign dp_in        = dp_r;
  assign duck_respawn = dr_r;
  assign game_over    = go_r;

endmodule

// File: tb/tb_ctl_score.sv
// Directed bench for ctl_score: expected outputs are queued as each step is driven
// and popped and compared one cycle later, when the registered outputs reflect it.
module tb_ctl_score;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame = 1'b0;
  logic       shot_fired = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] hex0, hex1, hex2, hex3, dp_in;
  logic       duck_respawn, game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] ammo;
    logic [7:0] score;
    logic       go;
    logic [3:0] dp;
    logic       dr;
  } exp_t;

  exp_t sb[$];

  localparam logic [3:0] DPP = 4'b1011;

  ctl_score dut (
    .clk          (clk),
    .rst          (rst),
    .new_frame    (new_frame),
    .shot_fired   (shot_fired),
    .hit          (hit),
    .miss         (miss),
    .hex0         (hex0),
    .hex1         (hex1),
    .hex2         (hex2),
    .hex3         (hex3),
    .dp_in        (dp_in),
    .duck_respawn (duck_respawn),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: queue empty got=0 exp=1");
      return;
    end
    e = sb.pop_front();
    total++;
    assert ({hex1, hex0} === e.ammo) else begin
      bad++;
      $error("FAIL %s ammo got=%h exp=%h", e.tag, {hex1, hex0}, e.ammo);
    end
    total++;
    assert ({hex3, hex2} === e.score) else begin
      bad++;
      $error("FAIL %s score got=%h exp=%h", e.tag, {hex3, hex2}, e.score);
    end
    total++;
    assert (game_over === e.go) else begin
      bad++;
      $error("FAIL %s game_over got=%b exp=%b", e.tag, game_over, e.go);
    end
    total++;
    assert (dp_in === e.dp) else begin
      bad++;
      $error("FAIL %s dp_in got=%b exp=%b", e.tag, dp_in, e.dp);
    end
    total++;
    assert (duck_respawn === e.dr) else begin
      bad++;
      $error("FAIL %s duck_respawn got=%b exp=%b", e.tag, duck_respawn, e.dr);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, queue the expectation, and
  // compare at the next falling edge after the registers have updated.
  task automatic step(input string tag, input logic r, input logic s, input logic h,
                      input logic m, input logic nf, input logic [7:0] ea,
                      input logic [7:0] es, input logic eg, input logic [3:0] ed,
                      input logic edr);
    exp_t e;
    rst        = r;
    shot_fired = s;
    hit        = h;
    miss       = m;
    new_frame  = nf;
    e.tag   = tag;
    e.ammo  = ea;
    e.score = es;
    e.go    = eg;
    e.dp    = ed;
    e.dr    = edr;
    sb.push_back(e);
    @(negedge clk);
    rst        = 1'b0;
    shot_fired = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    new_frame  = 1'b0;
    compare();
  endtask

  initial begin
    @(negedge clk);

    // reset state
    step("reset", 1, 0, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 0);
    step("reset_idle", 0, 0, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 0);

    // 20 shots down to 00 with BCD borrow; a miss with ammo left does nothing
    for (int i = 1; i <= 20; i++) begin
      step("shot_down", 0, 1, 0, 0, 0, bcd(20 - i), 8'h00, 0, DPP, 0);
      if (i == 10) step("miss_nonzero", 0, 0, 0, 1, 0, 8'h10, 8'h00, 0, DPP, 0);
    end
    step("shot_at_00", 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, DPP, 0);

    // shot + hit together, respawn after 60 frames, hit ignored while respawning
    step("reset2", 1, 0, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 0);
    step("shot_hit", 0, 1, 1, 0, 0, 8'h19, 8'h01, 0, DPP, 0);
    step("hit_in_respawn", 0, 0, 1, 1, 0, 8'h19, 8'h01, 0, DPP, 0);
    for (int f = 1; f <= 60; f++)
      step("respawn_frame", 0, 0, 0, 0, 1, 8'h19, 8'h01, 0, DPP, logic'(f == 60));
    step("respawn_one_cycle", 0, 0, 0, 0, 0, 8'h19, 8'h01, 0, DPP, 0);
    step("back_in_play_hit", 0, 0, 1, 0, 0, 8'h19, 8'h02, 0, DPP, 0);

    // score up to 99 then saturate
    step("reset3", 1, 0, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 0);
    for (int k = 1; k <= 99; k++) begin
      step("score_hit", 0, 0, 1, 0, 0, 8'h20, bcd(k), 0, DPP, 0);
      for (int f = 1; f <= 60; f++)
        step("score_frame", 0, 0, 0, 0, 1, 8'h20, bcd(k), 0, DPP, logic'(f == 60));
    end
    step("score_saturate", 0, 0, 1, 0, 0, 8'h20, 8'h99, 0, DPP, 0);

    // reach ammo 01 with score 01, then shot, miss -> OVER and blink
    step("reset4", 1, 0, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 0);
    step("shot_hit2", 0, 1, 1, 0, 0, 8'h19, 8'h01, 0, DPP, 0);
    for (int f = 1; f <= 60; f++)
      step("frame2", 0, 0, 0, 0, 1, 8'h19, 8'h01, 0, DPP, logic'(f == 60));
    for (int i = 1; i <= 18; i++)
      step("shot_to_01", 0, 1, 0, 0, 0, bcd(19 - i), 8'h01, 0, DPP, 0);
    step("last_shot", 0, 1, 0, 0, 0, 8'h00, 8'h01, 0, DPP, 0);
    step("miss_over", 0, 0, 0, 1, 0, 8'h00, 8'h01, 1, 4'b0000, 0);
    for (int f = 1; f <= 64; f++)
      step("blink", 0, 0, 0, 0, 1, 8'h00, 8'h01, 1,
           (f >= 32 && f < 64) ? 4'b1111 : 4'b0000, 0);
    step("hit_in_over", 0, 0, 1, 0, 0, 8'h00, 8'h01, 1, 4'b0000, 0);
    step("miss_in_over", 0, 0, 0, 1, 0, 8'h00, 8'h01, 1, 4'b0000, 0);

    // restart from OVER
    step("restart", 0, 1, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 1);
    step("restart_one_cycle", 0, 0, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 0);

    // shot and miss in the same cycle that empties the ammo
    for (int i = 1; i <= 19; i++)
      step("shot_again", 0, 1, 0, 0, 0, bcd(20 - i), 8'h00, 0, DPP, 0);
    step("shot_miss_same", 0, 1, 0, 1, 0, 8'h00, 8'h00, 1, 4'b0000, 0);

    // reset aborts RESPAWN at frame 30 with no respawn pulse afterwards
    step("reset5", 1, 0, 0, 0, 0, 8'h20, 8'h00, 0, DPP, 0);
    step("shot_hit3", 0, 1, 1, 0, 0, 8'h19, 8'h01, 0, DPP, 0);
    for (int f = 1; f <= 30; f++)
      step("pre_abort_frame", 0, 0, 0, 0, 1, 8'h19, 8'h01, 0, DPP, 0);
    step("rst_abort", 1, 1, 1, 0, 1, 8'h20, 8'h00, 0, DPP, 0);
    for (int f = 1; f <= 40; f++)
      step("post_abort_frame", 0, 0, 0, 0, 1, 8'h20, 8'h00, 0, DPP, 0);
    step("post_abort_hit", 0, 0, 1, 0, 0, 8'h20, 8'h01, 0, DPP, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
